// File: rtl/serial_subtractor_pkg.sv
// rtl/serial_subtractor_pkg.sv - shared types and constants for the bit-serial subtractor
//
// Package sub_pkg:
//   DEFAULT_WIDTH : default operand/result width
//   state_t       : sequencer state (IDLE, RUN, DONE)
package sub_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/serial_subtractor_if.sv
// rtl/serial_subtractor_if.sv - request/result bundle of the bit-serial subtractor
//
// Signals:
//   start      : request, sampled only while the subtractor is idle
//   a, b       : minuend / subtrahend, captured on an accepted start
//   busy       : high while bits are being processed
//   done       : one-cycle pulse when diff/borrow_out/overflow update
//   diff       : a - b mod 2^WIDTH, held until the next done
//   borrow_out : unsigned a < b
//   overflow   : signed two's-complement overflow of a - b
// Modports: master (requester side), slave (subtractor side).
interface serial_subtractor_if
  import sub_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) ();

  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             borrow_out;
  logic             overflow;

  modport master (
    output start, a, b,
    input  busy, done, diff, borrow_out, overflow
  );

  modport slave (
    input  start, a, b,
    output busy, done, diff, borrow_out, overflow
  );

endinterface

// File: rtl/serial_subtractor_full_subtractor.sv
// rtl/serial_subtractor_full_subtractor.sv - one-bit full subtractor cell (a - b - bin)
//
// Ports:
//   a, b, bin : minuend bit, subtrahend bit, borrow in
//   diff      : difference bit
//   borrow    : borrow out
module full_subtractor (
  output logic diff,
  output logic borrow,
  input  logic a,
  input  logic b,
  input  logic bin
);

  assign diff   = a ^ b ^ bin;
  assign borrow = (~a & b) | (~a & bin) | (b & bin);

endmodule

// File: rtl/serial_subtractor.sv
// rtl/serial_subtractor.sv - bit-serial WIDTH-bit subtractor, LSB first, one bit per clock
//
// Ports:
//   clk   : clock, all state changes on the rising edge
//   rst_n : synchronous active-low reset
//   bus   : serial_subtractor_if.slave (start/a/b in, busy/done/diff/borrow_out/overflow out)
module serial_subtractor
  import sub_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst_n,
  serial_subtractor_if.slave   bus
);

  localparam int CNT_W = $clog2(WIDTH);

  state_t           state;
  state_t           state_nxt;
  logic             busy_c;

  logic [WIDTH-1:0] sa;
  logic [WIDTH-1:0] sb;
  logic [WIDTH-1:0] res;
  logic             bff;
  logic [CNT_W-1:0] cnt;
  logic             a_msb;
  logic             b_msb;

  logic             done_q;
  logic [WIDTH-1:0] diff_q;
  logic             borrow_q;
  logic             overflow_q;

  logic             cell_d;
  logic             cell_bout;
  logic             last_bit;

  full_subtractor u_cell (
    .diff   (cell_d),
    .borrow (cell_bout),
    .a      (sa[0]),
    .b      (sb[0]),
    .bin    (bff)
  );

  assign last_bit = (cnt == CNT_W'(WIDTH - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    busy_c    = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.start) state_nxt = RUN;
      end
      RUN: begin
        busy_c = 1'b1;
        if (last_bit) state_nxt = DONE;
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sa         <= '0;
      sb         <= '0;
      res        <= '0;
      bff        <= 1'b0;
      cnt        <= '0;
      a_msb      <= 1'b0;
      b_msb      <= 1'b0;
      done_q     <= 1'b0;
      diff_q     <= '0;
      borrow_q   <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state)
        IDLE: begin
          if (bus.start) begin
            sa    <= bus.a;
            sb    <= bus.b;
            bff   <= 1'b0;
            cnt   <= '0;
            // Operand signs are kept because sa/sb are consumed by shifting.
            a_msb <= bus.a[WIDTH-1];
            b_msb <= bus.b[WIDTH-1];
          end
        end
        RUN: begin
          sa  <= {1'b0, sa[WIDTH-1:1]};
          sb  <= {1'b0, sb[WIDTH-1:1]};
          // Difference bits enter at the MSB so bit 0 ends up at res[0].
          res <= {cell_d, res[WIDTH-1:1]};
          bff <= cell_bout;
          cnt <= cnt + CNT_W'(1);
        end
        DONE: begin
          done_q     <= 1'b1;
          diff_q     <= res;
          borrow_q   <= bff;
          overflow_q <= (a_msb != b_msb) && (res[WIDTH-1] != a_msb);
        end
        default: begin
        end
      endcase
    end
  end

  assign bus.busy       = busy_c;
  assign bus.done       = done_q;
  assign bus.diff       = diff_q;
  assign bus.borrow_out = borrow_q;
  assign bus.overflow   = overflow_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// tb/tb_serial_subtractor.sv - self-checking bench for serial_subtractor
module tb_serial_subtractor;

  localparam int W = 8;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  serial_subtractor_if #(.WIDTH(W)) bus ();

  serial_subtractor #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: plain integer subtraction, unsigned compare and signed range test.
  function automatic void ref_sub(input logic [W-1:0] a, input logic [W-1:0] b,
                                  output logic [W-1:0] d, output logic bo, output logic ov);
    int ua, ub, ia, ib, r;
    ua = int'(a);
    ub = int'(b);
    ia = $signed(a);
    ib = $signed(b);
    r  = ia - ib;
    d  = W'(ua - ub);
    bo = (ua < ub);
    ov = (r > (2 ** (W - 1)) - 1) || (r < -(2 ** (W - 1)));
  endfunction

  // One operation: start is accepted at the first edge; k counts edges after it.
  // inj_k >= 1 pulses a stray start at that RUN cycle; rst_k >= 1 pulses reset there.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                        input int inj_k, input int rst_k, input string tag);
    logic [W-1:0] ed, pd;
    logic         eb, eo, pb, po;
    int           busy_cnt, done_k;
    bit           stable;
    ref_sub(a, b, ed, eb, eo);
    pd = bus.diff;
    pb = bus.borrow_out;
    po = bus.overflow;
    bus.a     = a;
    bus.b     = b;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    check({tag, "_done_low_at_start"}, bus.done, 1'b0);
    busy_cnt = bus.busy;
    done_k   = -1;
    stable   = (bus.diff === pd) && (bus.borrow_out === pb) && (bus.overflow === po);
    for (int k = 1; k <= 3 * W; k++) begin
      if (k == inj_k) begin
        bus.start = 1'b1;
        bus.a     = W'('hAA);
        bus.b     = W'('h55);
      end
      if (inj_k > 0 && k == inj_k + 1) bus.start = 1'b0;
      if (k == rst_k) rst_n = 1'b0;
      if (rst_k > 0 && k == rst_k + 1) rst_n = 1'b1;
      @(posedge clk);
      #1;
      if (bus.done === 1'b1) begin
        done_k = k;
        break;
      end
      busy_cnt += int'(bus.busy);
      if (rst_k < 0 &&
          !((bus.diff === pd) && (bus.borrow_out === pb) && (bus.overflow === po)))
        stable = 1'b0;
    end
    bus.start = 1'b0;
    rst_n     = 1'b1;
    if (rst_k < 0) begin
      check({tag, "_latency"},  done_k, W + 1);
      check({tag, "_busy_cyc"}, busy_cnt, W);
      check({tag, "_held"},     stable, 1'b1);
      check({tag, "_diff"},     bus.diff, ed);
      check({tag, "_borrow"},   bus.borrow_out, eb);
      check({tag, "_overflow"}, bus.overflow, eo);
    end else begin
      check({tag, "_no_done"},  done_k, -1);
      check({tag, "_busy"},     bus.busy, 1'b0);
      check({tag, "_diff"},     bus.diff, '0);
      check({tag, "_borrow"},   bus.borrow_out, 1'b0);
      check({tag, "_overflow"}, bus.overflow, 1'b0);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int extra;
    rst_n     = 1'b0;
    bus.start = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy",     bus.busy, 1'b0);
    check("rst_done",     bus.done, 1'b0);
    check("rst_diff",     bus.diff, '0);
    check("rst_borrow",   bus.borrow_out, 1'b0);
    check("rst_overflow", bus.overflow, 1'b0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    run_op(W'('h05), W'('h03), -1, -1, "t1_5m3");
    run_op(W'('h03), W'('h05), -1, -1, "t2_3m5");
    run_op(W'('h00), W'('h01), -1, -1, "t2_0m1");
    run_op(W'('h80), W'('h01), -1, -1, "t3_80m1");
    run_op(W'('h7F), W'('hFF), -1, -1, "t3_7fmff");
    run_op(W'('h5A), W'('h5A), -1, -1, "eq");
    run_op(W'('hC3), W'('h00), -1, -1, "b_zero");

    run_op(W'('h10), W'('h01), 4, -1, "t4_ignore");
    check("t4_diff_0f", bus.diff, W'('h0F));
    extra = 0;
    for (int k = 0; k < 3 * W; k++) begin
      @(posedge clk);
      #1;
      extra += int'(bus.done);
    end
    check("t4_single_done", extra, 0);

    run_op(W'('h20), W'('h10), -1, 3, "t5_reset");
    run_op(W'('h09), W'('h09), -1, -1, "t5_after");

    for (int i = 0; i < 1000; i++) begin
      run_op(W'($urandom_range(0, (1 << W) - 1)), W'($urandom_range(0, (1 << W) - 1)),
             -1, -1, "rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
